data_ram_init: RTL and testbench



---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_core.sv | 60 ++++++
 rtl/data_ram_init.sv | 104 ++++++++++
 tb/tb_data_ram_init.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_pkg : shared types and helpers for the data_ram_init memory slice |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ram_pkg;

    typedef enum logic {INIT, RUN} ram_state_t;

    function automatic int lanes(input int dataW, input int laneW);
        return dataW / laneW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_core : storage array, per-lane write port, write-first reg. read  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ram_core
    import ram_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AW-1:0]                      addr,
    input  logic                               wrEn,
    input  logic [lanes(DATA_W, LANE_W)-1:0]   wrBe,
    input  logic [DATA_W-1:0]                  wrData,
    input  logic                               rdEn,
    input  logic                               rdZero,
    output logic [DATA_W-1:0]                  rdData
);

    localparam int c_LANES = lanes(DATA_W, LANE_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdData;
    logic [DATA_W-1:0] w_merged;

    // Post-write view of the addressed word, so a same-edge read sees the new lanes.
    always_comb begin
        w_merged = r_mem[addr];
        for (int i = 0; i < c_LANES; i++) begin
            if (wrEn && wrBe[i]) begin
                w_merged[i*LANE_W +: LANE_W] = wrData[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_LANES; i++) begin
            if (wrEn && wrBe[i]) begin
                r_mem[addr][i*LANE_W +: LANE_W] <= wrData[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else if (rdEn) begin
            r_rdData <= rdZero ? '0 : w_merged;
        end
    end

    assign rdData = r_rdData;

endmodule
`default_nettype wire

// File: rtl/data_ram_init.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_ram_init : memory-stage data RAM with post-reset clear sweep     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module data_ram_init
    import ram_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         A,
    input  logic [DATA_W-1:0]         memWD,
    input  logic                      memWriteM,
    input  logic [DATA_W/LANE_W-1:0]  be,
    input  logic                      memReadM,
    output logic [DATA_W-1:0]         rdMemData,
    output logic                      rd_valid,
    output logic                      ready,
    output logic                      addr_err
);

    localparam int                 c_LANES = lanes(DATA_W, LANE_W);
    localparam int                 c_CNT_W = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEPTH - 1);

    ram_state_t           r_state;
    logic [c_CNT_W-1:0]   r_initCnt;
    logic                 r_ready;
    logic                 r_rdValid;
    logic                 r_addrErr;

    logic                 w_inRange;
    logic                 w_run;
    logic [c_CNT_W-1:0]   w_addr;
    logic                 w_wrEn;
    logic [c_LANES-1:0]   w_wrBe;
    logic [DATA_W-1:0]    w_wrData;
    logic                 w_rdEn;

    assign w_inRange = (64'(A) < 64'(DEPTH));
    assign w_run     = (r_state == RUN);

    // Sweep owns the single port in INIT; user requests only reach it in RUN.
    assign w_addr   = w_run ? A[c_CNT_W-1:0] : r_initCnt;
    assign w_wrEn   = !rst && (w_run ? (memWriteM && w_inRange) : 1'b1);
    assign w_wrBe   = w_run ? be : {c_LANES{1'b1}};
    assign w_wrData = w_run ? memWD : '0;
    assign w_rdEn   = !rst && w_run && memReadM;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_initCnt <= '0;
            r_ready   <= 1'b0;
            r_rdValid <= 1'b0;
            r_addrErr <= 1'b0;
        end else begin
            r_rdValid <= 1'b0;
            r_addrErr <= 1'b0;
            case (r_state)
                INIT: begin
                    r_initCnt <= r_initCnt + 1'b1;
                    if (r_initCnt == c_LAST) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_rdValid <= memReadM;
                    r_addrErr <= (memReadM || memWriteM) && !w_inRange;
                end
                default: r_state <= INIT;
            endcase
        end
    end

    ram_core #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .AW     (c_CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .addr   (w_addr),
        .wrEn   (w_wrEn),
        .wrBe   (w_wrBe),
        .wrData (w_wrData),
        .rdEn   (w_rdEn),
        .rdZero (!w_inRange),
        .rdData (rdMemData)
    );

    assign rd_valid = r_rdValid;
    assign ready    = r_ready;
    assign addr_err = r_addrErr;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_init.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_data_ram_init : random + directed bench against a word-array model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_data_ram_init;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A;
    logic [23:0] memWD;
    logic        memWriteM;
    logic [2:0]  be;
    logic        memReadM;
    logic [23:0] rdMemData;
    logic        rd_valid;
    logic        ready;
    logic        addr_err;

    int nChecks = 0;
    int nErrors = 0;

    data_ram_init #(
        .DATA_W (24),
        .LANE_W (8),
        .ADDR_W (16),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .memWD     (memWD),
        .memWriteM (memWriteM),
        .be        (be),
        .memReadM  (memReadM),
        .rdMemData (rdMemData),
        .rd_valid  (rd_valid),
        .ready     (ready),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Behavioural model: word array, cycles since reset, last read result.
    logic [23:0] mdl [DEPTH];
    int          sweepEdges;
    logic        expReady, expValid, expErr;
    logic [23:0] expRd;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                sweepEdges = 0;
                expReady = 1'b0; expValid = 1'b0; expErr = 1'b0; expRd = '0;
            end else if (!expReady) begin
                sweepEdges++;
                expValid = 1'b0; expErr = 1'b0;
                if (sweepEdges == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
                    expReady = 1'b1;
                end
            end else begin
                if (memWriteM && int'(A) < DEPTH)
                    for (int i = 0; i < 3; i++)
                        if (be[i]) mdl[int'(A)][i*8 +: 8] = memWD[i*8 +: 8];
                expErr   = (memWriteM || memReadM) && int'(A) >= DEPTH;
                expValid = memReadM;
                if (memReadM) expRd = (int'(A) < DEPTH) ? mdl[int'(A)] : 24'h0;
            end
            #1;
            chk("ready",     32'(ready),     32'(expReady));
            chk("rd_valid",  32'(rd_valid),  32'(expValid));
            chk("addr_err",  32'(addr_err),  32'(expErr));
            chk("rdMemData", 32'(rdMemData), 32'(expRd));
        end
    end

    task automatic drive(input logic w, input logic r, input logic [15:0] a,
                         input logic [23:0] d, input logic [2:0] b);
        @(negedge clk);
        rst = 1'b0; memWriteM = w; memReadM = r; A = a; memWD = d; be = b;
    endtask

    task automatic goIdle();
        memWriteM = 1'b0; memReadM = 1'b0;
    endtask

    task automatic readLit(input logic [15:0] a, input logic [23:0] exp, input string nm);
        drive(1'b0, 1'b1, a, 24'h0, 3'b000);
        @(negedge clk);
        chk(nm, 32'(rdMemData), 32'(exp));
        chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
        goIdle();
    endtask

    task automatic waitReady(input string nm);
        int n = 0;
        while (!ready && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        rst = 1'b1; memWriteM = 1'b0; memReadM = 1'b0; A = '0; memWD = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(ready),     32'd0);
        chk("rst_valid",  32'(rd_valid),  32'd0);
        chk("rst_err",    32'(addr_err),  32'd0);
        chk("rst_rdata",  32'(rdMemData), 32'd0);
        rst = 1'b0;
        waitReady("clear_len");

        for (int a = 0; a < DEPTH; a++) readLit(16'(a), 24'h0, "cleared");

        drive(1'b1, 1'b0, 16'd1, 24'h00000C, 3'b111);
        readLit(16'd1, 24'h00000C, "full_wr");

        drive(1'b1, 1'b0, 16'd2, 24'hAABBCC, 3'b111);
        drive(1'b1, 1'b0, 16'd2, 24'h112233, 3'b010);
        readLit(16'd2, 24'hAA22CC, "lanes");

        drive(1'b1, 1'b0, 16'd3, 24'h000001, 3'b111);
        drive(1'b1, 1'b1, 16'd3, 24'hFFFFFF, 3'b001);
        @(negedge clk);
        chk("collide", 32'(rdMemData), 32'h0000FF);
        goIdle();

        drive(1'b1, 1'b0, 16'h0010, 24'h123456, 3'b111);
        @(negedge clk);
        chk("oor_wr_err", 32'(addr_err), 32'd1);
        goIdle();
        drive(1'b0, 1'b1, 16'h0010, 24'h0, 3'b000);
        @(negedge clk);
        chk("oor_rd_err",  32'(addr_err),  32'd1);
        chk("oor_rd_data", 32'(rdMemData), 32'd0);
        goIdle();

        drive(1'b1, 1'b0, 16'd5, 24'h00ABCD, 3'b111);
        drive(1'b0, 1'b0, 16'd0, 24'h0, 3'b000);
        drive(1'b1, 1'b0, 16'd6, 24'h777777, 3'b000);
        readLit(16'd6, 24'h0, "be_zero");
        readLit(16'd5, 24'h00ABCD, "pre_rst");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        waitReady("resweep_len");
        readLit(16'd5, 24'h0, "post_rst");

        // Randomised traffic, including occasional resets, checked every cycle by the model.
        for (int it = 0; it < 600; it++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 19)), 24'($urandom), 3'($urandom));
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
        end
        drive(1'b0, 1'b0, 16'd0, 24'h0, 3'b000);
        repeat (DEPTH + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
